// File: rtl/cam_wr_packer_pkg.sv
// Shared definitions for the camera write packer.
// Holds the FSM state encoding, the word-FIFO entry layout
// {data[127:0], addr[24:0]} and the default frame constants
// (640x480 RGB565, 8 pixels per 128-bit word).
package cam_wr_packer_pkg;

  localparam int unsigned ADDR_W       = 25;
  localparam int unsigned DATA_W       = 128;
  localparam int unsigned PIX_W        = 16;
  localparam int unsigned PIX_PER_WORD = DATA_W / PIX_W;
  localparam int unsigned ENTRY_W      = DATA_W + ADDR_W;

  localparam int unsigned       DEF_WORDS_PER_FRAME = 38400;
  localparam int unsigned       DEF_ADDR_STEP       = 8;
  localparam logic [ADDR_W-1:0] DEF_BUF1_BASE       = 25'h0100000;
  localparam int unsigned       DEF_FIFO_DEPTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } fifo_entry_t;

endpackage

// File: rtl/cam_wr_packer_fifo.sv
// pack_fifo: small synchronous FIFO holding packed words with their
// DDR addresses.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (empties FIFO)
//   push_i, wdata_i  write strobe and entry; accepted when not full, or
//                    when full and a pop happens in the same cycle
//   pop_i            read strobe; ignored when empty
//   rdata_o          head entry (first-word fall-through)
//   full_o, empty_o  occupancy flags
// DEPTH must be a power of two, 2 or more.
module pack_fifo #(
  parameter int unsigned WIDTH = 153,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // Pop frees the head slot in the same edge, so push-on-full is legal then.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/cam_wr_packer.sv
// cam_wr_packer: packs 16-bit RGB565 camera pixels into 128-bit words and
// issues them as DDR write requests into one of two frame buffers.
// Ports:
//   clk_133M, rst_133M   clock, synchronous active-high reset
//   pixel_data/valid     pixel stream (one-cycle strobes)
//   frame_start          one-cycle pulse before the first pixel of a frame
//   busy                 downstream cannot take a request this cycle
//   camera_wr_req        one-cycle request, one FIFO word per request
//   camera_wr_address    word address (buffer base + index*ADDR_STEP)
//   camera_wr_data       8 packed pixels, first pixel in [15:0]
//   frame_done           pulse once the last word of a frame has gone out
//   ready_buf            buffer index of the last completed frame
//   overflow             sticky: a word was dropped on a full FIFO
//   frame_error          sticky: frame_start arrived mid-frame
module cam_wr_packer
  import cam_wr_packer_pkg::*;
#(
  parameter int unsigned       WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
  parameter int unsigned       ADDR_STEP       = DEF_ADDR_STEP,
  parameter logic [24:0]       BUF1_BASE       = DEF_BUF1_BASE,
  parameter int unsigned       FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic         clk_133M,
  input  logic         rst_133M,
  input  logic [15:0]  pixel_data,
  input  logic         pixel_valid,
  input  logic         frame_start,
  input  logic         busy,
  output logic         camera_wr_req,
  output logic [24:0]  camera_wr_address,
  output logic [127:0] camera_wr_data,
  output logic         frame_done,
  output logic         ready_buf,
  output logic         overflow,
  output logic         frame_error
);

  localparam int unsigned        IDX_W    = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [ADDR_W-1:0]  STEP     = ADDR_W'(ADDR_STEP);

  state_e              state_q, state_d;
  logic [2:0]          pix_cnt_q;
  logic [DATA_W-1:0]   acc_q;
  logic [IDX_W-1:0]    word_idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                cur_buf_q, ready_buf_q;
  logic                pend_q;
  fifo_entry_t         pend_entry_q;
  logic                overflow_q, frame_error_q, frame_done_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;

  logic                fifo_full, fifo_empty, fifo_pop;
  fifo_entry_t         head;

  logic [2:0]          pix_idx;
  logic [IDX_W-1:0]    idx_cur;
  logic [ADDR_W-1:0]   addr_cur, base_addr;
  logic                pix_take, word_done, last_word, drain_done;

  assign base_addr = cur_buf_q ? BUF1_BASE : '0;

  // Requests come straight off the FIFO head; reset masks the cycle in
  // which the FIFO is being flushed.
  assign fifo_pop = !fifo_empty && !busy && !rst_133M;

  pack_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_133M),
    .rst_i   (rst_133M),
    .push_i  (pend_q),
    .pop_i   (fifo_pop),
    .wdata_i (pend_entry_q),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // frame_start restarts the frame before a same-cycle pixel is taken, so
  // that pixel is slot 0 of word 0 in the (kept) current buffer.
  always_comb begin
    state_d    = state_q;
    pix_idx    = frame_start ? 3'd0 : pix_cnt_q;
    idx_cur    = frame_start ? '0 : word_idx_q;
    addr_cur   = frame_start ? base_addr : addr_q;
    pix_take   = pixel_valid && (frame_start || state_q == ST_CAPTURE);
    word_done  = pix_take && (pix_idx == 3'd7);
    last_word  = word_done && (idx_cur == LAST_IDX);
    // Done only once the last completed word has left the FIFO.
    drain_done = (state_q == ST_DRAIN) && !frame_start && !pend_q && fifo_empty;
    unique case (state_q)
      ST_IDLE:    if (frame_start) state_d = ST_CAPTURE;
      ST_CAPTURE: if (last_word)   state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (frame_start)     state_d = ST_CAPTURE;
        else if (drain_done) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_133M) begin
    if (rst_133M) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      pix_cnt_q     <= '0;
      acc_q         <= '0;
      word_idx_q    <= '0;
      addr_q        <= '0;
      cur_buf_q     <= 1'b0;
      ready_buf_q   <= 1'b0;
      pend_q        <= 1'b0;
      pend_entry_q  <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
      frame_done_q  <= 1'b0;
      out_data_q    <= '0;
      out_addr_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;

      if (frame_start) begin
        acc_q      <= '0;
        pix_cnt_q  <= '0;
        word_idx_q <= '0;
        addr_q     <= base_addr;
        if (state_q != ST_IDLE) frame_error_q <= 1'b1;
      end

      if (pix_take) begin
        if (word_done) begin
          // Word and its address are staged together; the address advances
          // even if the FIFO later drops the word, keeping frame length.
          pend_entry_q.data <= {pixel_data, acc_q[DATA_W-PIX_W-1:0]};
          pend_entry_q.addr <= addr_cur;
          pix_cnt_q         <= '0;
          word_idx_q        <= last_word ? '0 : idx_cur + 1'b1;
          addr_q            <= addr_cur + STEP;
        end else begin
          acc_q[{pix_idx, 4'b0000} +: PIX_W] <= pixel_data;
          pix_cnt_q                          <= pix_idx + 3'd1;
        end
      end

      pend_q <= word_done;
      if (pend_q && fifo_full && !fifo_pop) overflow_q <= 1'b1;

      if (fifo_pop) begin
        out_data_q <= head.data;
        out_addr_q <= head.addr;
      end

      if (drain_done) begin
        frame_done_q <= 1'b1;
        ready_buf_q  <= cur_buf_q;
        cur_buf_q    <= ~cur_buf_q;
      end
    end
  end

  assign camera_wr_req     = fifo_pop;
  assign camera_wr_data    = fifo_pop ? head.data : out_data_q;
  assign camera_wr_address = fifo_pop ? head.addr : out_addr_q;
  assign frame_done        = frame_done_q;
  assign ready_buf         = ready_buf_q;
  assign overflow          = overflow_q;
  assign frame_error       = frame_error_q;

endmodule

// File: tb/tb_cam_wr_packer.sv
module tb_cam_wr_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pv, fs, busy;
  logic [15:0] pd;

  logic         req4, fd4, rb4, ov4, fe4;
  logic [24:0]  addr4;
  logic [127:0] data4;
  logic         req8, fd8, rb8, ov8, fe8;
  logic [24:0]  addr8;
  logic [127:0] data8;

  cam_wr_packer #(
    .WORDS_PER_FRAME (4),
    .ADDR_STEP       (8),
    .BUF1_BASE       (25'h0100000),
    .FIFO_DEPTH      (4)
  ) u4 (
    .clk_133M (clk), .rst_133M (rst), .pixel_data (pd), .pixel_valid (pv),
    .frame_start (fs), .busy (busy), .camera_wr_req (req4),
    .camera_wr_address (addr4), .camera_wr_data (data4), .frame_done (fd4),
    .ready_buf (rb4), .overflow (ov4), .frame_error (fe4)
  );

  cam_wr_packer #(
    .WORDS_PER_FRAME (8),
    .ADDR_STEP       (8),
    .BUF1_BASE       (25'h0100000),
    .FIFO_DEPTH      (4)
  ) u8 (
    .clk_133M (clk), .rst_133M (rst), .pixel_data (pd), .pixel_valid (pv),
    .frame_start (fs), .busy (busy), .camera_wr_req (req8),
    .camera_wr_address (addr8), .camera_wr_data (data8), .frame_done (fd8),
    .ready_buf (rb8), .overflow (ov8), .frame_error (fe8)
  );

  int checks = 0;
  int failures = 0;

  // Request / frame_done logs, sampled mid-cycle.
  logic [24:0]  a4 [256];
  logic [127:0] d4 [256];
  logic [24:0]  a8 [256];
  logic [127:0] d8 [256];
  int n4 = 0, n8 = 0, fd4_n = 0, fd8_n = 0;
  logic rb4_fd = 1'b0;

  always @(negedge clk) begin
    if (req4 && n4 < 256) begin a4[n4] = addr4; d4[n4] = data4; n4++; end
    if (req8 && n8 < 256) begin a8[n8] = addr8; d8[n8] = data8; n8++; end
    if (fd4) begin fd4_n++; rb4_fd = rb4; end
    if (fd8) fd8_n++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [15:0] d);
    pv = 1'b1; pd = d;
    tick();
    pv = 1'b0;
  endtask

  task automatic word(input logic [15:0] b);
    for (int k = 0; k < 8; k++) pix(b + 16'(k));
  endtask

  task automatic start_frame();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; pv = 1'b0; fs = 1'b0; busy = 1'b0; pd = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Pixel k of a word built from base b is b+k, placed at [16k+15:16k].
  function automatic logic [127:0] wexp(input logic [15:0] b);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = b + 16'(k);
    return r;
  endfunction

  int b4, b8, f4;

  initial begin
    rst = 1'b1; pv = 1'b0; fs = 1'b0; busy = 1'b0; pd = '0;

    // ---- reset state
    do_reset();
    chk("reset_ctl4", 128'({req4, fd4, rb4, ov4, fe4}), 128'(0));
    chk("reset_addr4", 128'(addr4), 128'(0));
    chk("reset_data4", data4, 128'(0));

    // ---- test 1: one word, latency 2
    b4 = n4;
    start_frame();
    for (int k = 1; k <= 7; k++) pix(16'(k));
    pv = 1'b1; pd = 16'h0008;
    @(posedge clk); #1;
    pv = 1'b0;
    @(negedge clk);
    chk("t1_req_at_t+1", 128'(req4), 128'(0));
    @(posedge clk);
    @(negedge clk);
    chk("t1_req_at_t+2", 128'(req4), 128'(1));
    chk("t1_data", data4, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_addr", 128'(addr4), 128'(0));
    repeat (5) tick();
    chk("t1_nreq", 128'(n4 - b4), 128'(1));
    chk("t1_hold_data", data4, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

    // ---- test 2: two 4-word frames, buffer ping-pong
    do_reset();
    b4 = n4; f4 = fd4_n;
    start_frame();
    for (int w = 0; w < 4; w++) word(16'h1000 + 16'(16*w));
    repeat (8) tick();
    chk("t2_nreq_f0", 128'(n4 - b4), 128'(4));
    chk("t2_a0", 128'(a4[b4+0]), 128'(25'd0));
    chk("t2_a1", 128'(a4[b4+1]), 128'(25'd8));
    chk("t2_a2", 128'(a4[b4+2]), 128'(25'd16));
    chk("t2_a3", 128'(a4[b4+3]), 128'(25'd24));
    chk("t2_d0", d4[b4+0], wexp(16'h1000));
    chk("t2_d3", d4[b4+3], wexp(16'h1030));
    chk("t2_fd_f0", 128'(fd4_n - f4), 128'(1));
    chk("t2_rb_f0", 128'(rb4_fd), 128'(0));
    start_frame();
    for (int w = 0; w < 4; w++) word(16'h1100 + 16'(16*w));
    repeat (8) tick();
    chk("t2_nreq_f1", 128'(n4 - b4), 128'(8));
    chk("t2_b1_a0", 128'(a4[b4+4]), 128'(25'h0100000));
    chk("t2_b1_a1", 128'(a4[b4+5]), 128'(25'h0100008));
    chk("t2_b1_a2", 128'(a4[b4+6]), 128'(25'h0100010));
    chk("t2_b1_a3", 128'(a4[b4+7]), 128'(25'h0100018));
    chk("t2_fd_f1", 128'(fd4_n - f4), 128'(2));
    chk("t2_rb_f1", 128'(rb4_fd), 128'(1));
    chk("t2_rb_out", 128'(rb4), 128'(1));
    chk("t2_no_err", 128'({ov4, fe4}), 128'(0));

    // ---- test 5: reset mid-frame with 2 words queued
    b4 = n4; f4 = fd4_n;
    busy = 1'b1;
    start_frame();
    word(16'h5000);
    word(16'h5010);
    repeat (2) tick();
    rst = 1'b1; busy = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5_ctl", 128'({req4, fd4, rb4, ov4, fe4}), 128'(0));
    chk("t5_addr", 128'(addr4), 128'(0));
    chk("t5_data", data4, 128'(0));
    repeat (6) tick();
    chk("t5_nreq", 128'(n4 - b4), 128'(0));
    word(16'h5100);
    repeat (4) tick();
    chk("t5_idle_ignores", 128'(n4 - b4), 128'(0));
    chk("t5_fd", 128'(fd4_n - f4), 128'(0));

    // ---- test 3: busy while 6 words arrive, 8-word frame
    do_reset();
    b8 = n8;
    busy = 1'b1;
    start_frame();
    for (int w = 0; w < 6; w++) word(16'h2000 + 16'(16*w));
    repeat (4) tick();
    chk("t3_ovf", 128'(ov8), 128'(1));
    chk("t3_nreq_busy", 128'(n8 - b8), 128'(0));
    busy = 1'b0;
    repeat (8) tick();
    chk("t3_nreq", 128'(n8 - b8), 128'(4));
    chk("t3_a0", 128'(a8[b8+0]), 128'(25'd0));
    chk("t3_a3", 128'(a8[b8+3]), 128'(25'd24));
    chk("t3_d0", d8[b8+0], wexp(16'h2000));
    chk("t3_d3", d8[b8+3], wexp(16'h2030));
    word(16'h2060);
    word(16'h2070);
    repeat (8) tick();
    chk("t3_nreq_end", 128'(n8 - b8), 128'(6));
    chk("t3_a6", 128'(a8[b8+4]), 128'(25'd48));
    chk("t3_a7", 128'(a8[b8+5]), 128'(25'd56));
    chk("t3_d6", d8[b8+4], wexp(16'h2060));
    chk("t3_fd", 128'(fd8_n), 128'(1));

    // ---- test 4: frame_start after 3 of 4 words
    do_reset();
    b4 = n4; f4 = fd4_n;
    busy = 1'b1;
    start_frame();
    for (int w = 0; w < 3; w++) word(16'h3000 + 16'(16*w));
    tick();
    start_frame();
    chk("t4_ferr", 128'(fe4), 128'(1));
    busy = 1'b0;
    repeat (6) tick();
    chk("t4_nreq_old", 128'(n4 - b4), 128'(3));
    chk("t4_a0", 128'(a4[b4+0]), 128'(25'd0));
    chk("t4_a2", 128'(a4[b4+2]), 128'(25'd16));
    chk("t4_d2", d4[b4+2], wexp(16'h3020));
    word(16'h3100);
    repeat (6) tick();
    chk("t4_nreq_new", 128'(n4 - b4), 128'(4));
    chk("t4_new_addr", 128'(a4[b4+3]), 128'(25'd0));
    chk("t4_new_data", d4[b4+3], wexp(16'h3100));
    chk("t4_no_fd", 128'(fd4_n - f4), 128'(0));
    chk("t4_no_ovf", 128'(ov4), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
